// File: rtl/obi_req_buffer.sv
// obi_req_buffer: queues OBI requests ahead of the CDC stage and caps the
// number of accepted-but-unanswered transactions. Responses pass straight
// through; a response with nothing pending latches a sticky error.
module obi_req_buffer #(
  parameter int DEPTH           = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // upstream (controller) port
  input  logic        ctrl_req_i,
  output logic        ctrl_gnt_o,
  input  logic [31:0] ctrl_addr_i,
  input  logic        ctrl_we_i,
  input  logic [3:0]  ctrl_be_i,
  input  logic [31:0] ctrl_wdata_i,
  output logic        ctrl_rvalid_o,
  output logic [31:0] ctrl_rdata_o,
  // downstream (CDC primary) port
  output logic        secondary_req_o,
  input  logic        secondary_gnt_i,
  output logic [31:0] secondary_addr_o,
  output logic        secondary_we_o,
  output logic [3:0]  secondary_be_o,
  output logic [31:0] secondary_wdata_o,
  input  logic        secondary_rvalid_i,
  input  logic [31:0] secondary_rdata_i,
  output logic        err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [PW:0]   PTR_ONE = (PW + 1)'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          wr_entry;
  entry_t          head;
  logic [PW:0]     wptr, rptr;
  logic [CW-1:0]   pending;
  logic            full, empty, room;
  logic            push, pop, dec;

  assign empty = (wptr == rptr);
  assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign room  = (pending < CNT_MAX);

  // Grant uses only the request and registered state, so the CDC side never
  // sees a combinational loop back through the controller.
  assign ctrl_gnt_o = ctrl_req_i && !rst_i && !full && room;
  assign push       = ctrl_gnt_o;
  assign pop        = !empty && secondary_gnt_i;
  assign dec        = secondary_rvalid_i && (pending != '0);

  assign wr_entry = '{addr: ctrl_addr_i, we: ctrl_we_i, be: ctrl_be_i, wdata: ctrl_wdata_i};
  assign head     = mem[rptr[PW-1:0]];

  assign secondary_req_o   = !empty;
  assign secondary_addr_o  = head.addr;
  assign secondary_we_o    = head.we;
  assign secondary_be_o    = head.be;
  assign secondary_wdata_o = head.wdata;

  // Responses are in-order and need no buffering.
  assign ctrl_rvalid_o = secondary_rvalid_i;
  assign ctrl_rdata_o  = secondary_rdata_i;

  // Entry storage; cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wptr[PW-1:0]] <= wr_entry;
    end
  end

  // FIFO pointers; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
    end
  end

  // Outstanding-transaction count and sticky error on an unexpected response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending <= '0;
      err_o   <= 1'b0;
    end else begin
      if (push && !dec)      pending <= pending + CNT_ONE;
      else if (!push && dec) pending <= pending - CNT_ONE;
      if (secondary_rvalid_i && (pending == '0)) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_obi_req_buffer.sv
// Directed bench for obi_req_buffer with hand-computed expectations.
module tb_obi_req_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ctrl_req_i;
  logic        ctrl_gnt_o;
  logic [31:0] ctrl_addr_i;
  logic        ctrl_we_i;
  logic [3:0]  ctrl_be_i;
  logic [31:0] ctrl_wdata_i;
  logic        ctrl_rvalid_o;
  logic [31:0] ctrl_rdata_o;
  logic        secondary_req_o;
  logic        secondary_gnt_i;
  logic [31:0] secondary_addr_o;
  logic        secondary_we_o;
  logic [3:0]  secondary_be_o;
  logic [31:0] secondary_wdata_o;
  logic        secondary_rvalid_i;
  logic [31:0] secondary_rdata_i;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  obi_req_buffer #(.DEPTH(2), .MAX_OUTSTANDING(4)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .ctrl_req_i        (ctrl_req_i),
    .ctrl_gnt_o        (ctrl_gnt_o),
    .ctrl_addr_i       (ctrl_addr_i),
    .ctrl_we_i         (ctrl_we_i),
    .ctrl_be_i         (ctrl_be_i),
    .ctrl_wdata_i      (ctrl_wdata_i),
    .ctrl_rvalid_o     (ctrl_rvalid_o),
    .ctrl_rdata_o      (ctrl_rdata_o),
    .secondary_req_o   (secondary_req_o),
    .secondary_gnt_i   (secondary_gnt_i),
    .secondary_addr_o  (secondary_addr_o),
    .secondary_we_o    (secondary_we_o),
    .secondary_be_o    (secondary_be_o),
    .secondary_wdata_o (secondary_wdata_o),
    .secondary_rvalid_i(secondary_rvalid_i),
    .secondary_rdata_i (secondary_rdata_i),
    .err_o             (err_o)
  );

  always #5 clk_i = ~clk_i;

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_i = 1'b1; ctrl_req_i = 1'b1; ctrl_addr_i = '0; ctrl_we_i = 1'b0;
    ctrl_be_i = '0; ctrl_wdata_i = '0; secondary_gnt_i = 1'b0;
    secondary_rvalid_i = 1'b0; secondary_rdata_i = '0;
    #1;
    check("gnt_in_reset", 32'(ctrl_gnt_o), 32'd0);
    step(); step();
    rst_i = 1'b0; ctrl_req_i = 1'b0;
    #1;
    check("rst_sreq", 32'(secondary_req_o), 32'd0);
    check("rst_addr", secondary_addr_o, 32'd0);
    check("rst_wdata", secondary_wdata_o, 32'd0);
    check("rst_be", 32'(secondary_be_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);

    // single write
    ctrl_req_i = 1'b1; ctrl_addr_i = 32'h1000_0004; ctrl_we_i = 1'b1;
    ctrl_be_i = 4'hF; ctrl_wdata_i = 32'hDEAD_BEEF;
    #1;
    check("wr_gnt", 32'(ctrl_gnt_o), 32'd1);
    step();
    ctrl_req_i = 1'b0; ctrl_we_i = 1'b0; ctrl_wdata_i = '0; ctrl_addr_i = '0;
    #1;
    check("wr_sreq", 32'(secondary_req_o), 32'd1);
    check("wr_addr", secondary_addr_o, 32'h1000_0004);
    check("wr_we", 32'(secondary_we_o), 32'd1);
    check("wr_be", 32'(secondary_be_o), 32'hF);
    check("wr_wdata", secondary_wdata_o, 32'hDEAD_BEEF);
    secondary_gnt_i = 1'b1;
    step();
    secondary_gnt_i = 1'b0;
    #1;
    check("wr_popped", 32'(secondary_req_o), 32'd0);
    secondary_rvalid_i = 1'b1; secondary_rdata_i = 32'h1234_5678;
    #1;
    check("wr_rvalid", 32'(ctrl_rvalid_o), 32'd1);
    check("wr_rdata", ctrl_rdata_o, 32'h1234_5678);
    step();
    secondary_rvalid_i = 1'b0;
    #1;
    check("wr_no_err", 32'(err_o), 32'd0);

    // three back-to-back reads into a 2-deep FIFO with downstream stalled
    ctrl_req_i = 1'b1; ctrl_addr_i = 32'h0;
    #1;
    check("rd0_gnt", 32'(ctrl_gnt_o), 32'd1);
    step();
    ctrl_addr_i = 32'h4;
    #1;
    check("rd1_gnt", 32'(ctrl_gnt_o), 32'd1);
    step();
    ctrl_addr_i = 32'h8;
    #1;
    check("rd2_stall", 32'(ctrl_gnt_o), 32'd0);
    check("head0", secondary_addr_o, 32'h0);
    step();
    check("rd2_stall2", 32'(ctrl_gnt_o), 32'd0);
    check("head0_stable", secondary_addr_o, 32'h0);
    check("head0_req", 32'(secondary_req_o), 32'd1);
    secondary_gnt_i = 1'b1;
    #1;
    check("full_pop_blocks_push", 32'(ctrl_gnt_o), 32'd0);
    step();
    check("head1", secondary_addr_o, 32'h4);
    check("rd2_gnt", 32'(ctrl_gnt_o), 32'd1);
    step();  // push 0x8 while popping 0x4
    ctrl_req_i = 1'b0;
    #1;
    check("head2", secondary_addr_o, 32'h8);
    check("occ1_req", 32'(secondary_req_o), 32'd1);
    step();
    secondary_gnt_i = 1'b0;
    #1;
    check("occ_stayed_1", 32'(secondary_req_o), 32'd0);
    secondary_rvalid_i = 1'b1;
    step(); step(); step();
    secondary_rvalid_i = 1'b0;
    #1;
    check("drain3_no_err", 32'(err_o), 32'd0);

    // outstanding limit with instant downstream grants
    secondary_gnt_i = 1'b1; ctrl_req_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ctrl_addr_i = 32'h100 + 32'(i * 4);
      #1;
      check($sformatf("lim_gnt%0d", i), 32'(ctrl_gnt_o), 32'd1);
      step();
    end
    check("lim_reached", 32'(ctrl_gnt_o), 32'd0);
    step();
    check("lim_hold", 32'(ctrl_gnt_o), 32'd0);
    secondary_rvalid_i = 1'b1;
    #1;
    check("lim_no_comb", 32'(ctrl_gnt_o), 32'd0);
    step();
    secondary_rvalid_i = 1'b0;
    #1;
    check("lim_release", 32'(ctrl_gnt_o), 32'd1);
    secondary_rvalid_i = 1'b1;  // accept and response together: pending stays 3
    step();
    secondary_rvalid_i = 1'b0;
    #1;
    check("acc_rv_same", 32'(ctrl_gnt_o), 32'd1);
    step();
    check("lim_again", 32'(ctrl_gnt_o), 32'd0);
    ctrl_req_i = 1'b0;
    secondary_rvalid_i = 1'b1;
    step(); step(); step(); step();
    secondary_rvalid_i = 1'b0;
    #1;
    check("drain4_no_err", 32'(err_o), 32'd0);

    // unexpected response
    secondary_rvalid_i = 1'b1;
    #1;
    check("err_not_yet", 32'(err_o), 32'd0);
    step();
    secondary_rvalid_i = 1'b0;
    #1;
    check("err_set", 32'(err_o), 32'd1);
    step();
    check("err_sticky", 32'(err_o), 32'd1);
    ctrl_req_i = 1'b1;
    #1;
    check("no_underflow", 32'(ctrl_gnt_o), 32'd1);
    ctrl_req_i = 1'b0;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
    check("err_cleared", 32'(err_o), 32'd0);

    // reset mid-operation: 2 queued, 3 pending
    secondary_gnt_i = 1'b0; ctrl_req_i = 1'b1; ctrl_addr_i = 32'h200;
    step();
    secondary_gnt_i = 1'b1; ctrl_addr_i = 32'h204;
    step();
    secondary_gnt_i = 1'b0; ctrl_addr_i = 32'h208;
    step();
    check("mid_full", 32'(ctrl_gnt_o), 32'd0);
    check("mid_head", secondary_addr_o, 32'h204);
    rst_i = 1'b1;
    #1;
    check("mid_gnt_rst", 32'(ctrl_gnt_o), 32'd0);
    step();
    rst_i = 1'b0; ctrl_req_i = 1'b0;
    #1;
    check("mid_sreq", 32'(secondary_req_o), 32'd0);
    check("mid_addr", secondary_addr_o, 32'd0);
    secondary_rvalid_i = 1'b1;
    step();
    secondary_rvalid_i = 1'b0;
    #1;
    check("mid_late_rsp_err", 32'(err_o), 32'd1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    secondary_gnt_i = 1'b1; ctrl_req_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ctrl_addr_i = 32'h300 + 32'(i * 4);
      #1;
      check($sformatf("cap_gnt%0d", i), 32'(ctrl_gnt_o), 32'd1);
      step();
    end
    check("cap_limit", 32'(ctrl_gnt_o), 32'd0);
    ctrl_req_i = 1'b0; secondary_gnt_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
